// File: rtl/fifo_thr_pkg.sv
// fifo_thr_pkg: shared defaults and sizing helper for the threshold FIFO
package fifo_thr_pkg;
  localparam int DEF_DATA_W = 6;
  localparam int DEF_DEPTH = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_thr_mem_dp.sv
// mem_dp: one write port, one registered read port; the array itself is never reset
module mem_dp import fifo_thr_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // Non-blocking update gives read-before-write on a same-address collision
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fifo_thr.sv
// fifo_thr: FIFO with live almost-full/empty thresholds and overflow/underflow error flags
module fifo_thr import fifo_thr_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int ADDR_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_wr,
  input  logic              fifo_rd,
  input  logic [CNT_W-1:0]  afull_thr,
  input  logic [CNT_W-1:0]  aempty_thr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              err_fifo,
  output logic              err_sticky
);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic rd_ok, wr_ok, err_next;
  assign fifo_empty = count == '0;
  assign fifo_full = count == CNT_W'(DEPTH);
  assign almost_full = count >= afull_thr;
  assign almost_empty = count <= aempty_thr;
  assign fifo_count = count;
  // A read on empty is never accepted, so a full FIFO only frees a slot via a real read
  assign rd_ok = fifo_rd && !fifo_empty;
  assign wr_ok = fifo_wr && (!fifo_full || rd_ok);
  assign err_next = (fifo_wr && !wr_ok) || (fifo_rd && !rd_ok);
  always_ff @(posedge clk or posedge RESET)
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      data_valid <= 1'b0;
      err_fifo <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr == ADDR_W'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr == ADDR_W'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
      data_valid <= rd_ok;
      err_fifo <= err_next;
      err_sticky <= err_sticky | err_next;
    end
  mem_dp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .rst(RESET),
    .we(wr_ok),
    .waddr(wr_ptr),
    .wdata(data_in),
    .re(rd_ok),
    .raddr(rd_ptr),
    .rdata(data_out)
  );
endmodule
